// File: rtl/vector_instr_queue_if.sv
// Handshake bundle between the scalar issue port, the vector instruction queue and dispatch.
// master: the side that drives push_valid/push_data/ready/flush. slave: the queue itself.
// Signals: push_valid/push_data/push_ready (scalar side), instruction/valid_fifo/ready (dispatch side),
//          flush (discard all), count/almost_full (occupancy status).
interface vector_instr_queue_if #(
    parameter int DATA_FROM_SCALAR = 96,
    parameter int DEPTH            = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                        push_valid;
    logic [DATA_FROM_SCALAR-1:0] push_data;
    logic                        push_ready;
    logic [DATA_FROM_SCALAR-1:0] instruction;
    logic                        valid_fifo;
    logic                        ready;
    logic                        flush;
    logic [CW-1:0]               count;
    logic                        almost_full;

    modport master (
        output push_valid, push_data, ready, flush,
        input  push_ready, instruction, valid_fifo, count, almost_full
    );

    modport slave (
        input  push_valid, push_data, ready, flush,
        output push_ready, instruction, valid_fifo, count, almost_full
    );
endinterface

// File: rtl/vector_instr_queue.sv
// Purpose: in-order FWFT queue of vector instruction packets between scalar issue and vector dispatch.
// Latency: 1 cycle push-to-head (no bypass when empty); pop exposes the next entry after the same edge.
// Backpressure: push_ready = !full only (never depends on ready); flush drops everything, beating push/pop.
// Ports: clk, rst (async active-low); q_if.slave carries push_valid/push_data/push_ready,
//        instruction/valid_fifo/ready, flush, count and almost_full.
module vector_instr_queue #(
    parameter int DATA_FROM_SCALAR  = 96,
    parameter int DEPTH             = 8,
    parameter int ALMOST_FULL_LEVEL = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_instr_queue_if.slave   q_if
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [CW-1:0]               count_q;

    logic full;
    logic empty;
    logic push_evt;
    logic pop_evt;

    // Occupancy counter is the only full/empty source; pointers wrap freely mod DEPTH.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    // A push offered while full is dropped even if a pop frees a slot this cycle,
    // which keeps push_ready free of any path from ready.
    assign push_evt = q_if.push_valid & ~full;
    assign pop_evt  = q_if.ready & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (q_if.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_evt) wr_ptr <= wr_ptr + PW'(1);
            if (pop_evt)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_evt, pop_evt})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; stale entries are never visible because
    // the head is zero-gated whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push_evt && !q_if.flush) begin
            mem[wr_ptr] <= q_if.push_data;
        end
    end

    assign q_if.push_ready  = ~full;
    assign q_if.valid_fifo  = ~empty;
    assign q_if.instruction = empty ? '0 : mem[rd_ptr];
    assign q_if.count       = count_q;
    assign q_if.almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
endmodule

// File: tb/tb_vector_instr_queue.sv
// Bench for vector_instr_queue: scoreboard of accepted packets, head and status checked every cycle.
module tb_vector_instr_queue;
    localparam int DW  = 96;
    localparam int DEP = 8;
    localparam int AFL = 6;

    logic clk;
    logic rst;

    vector_instr_queue_if #(.DATA_FROM_SCALAR(DW), .DEPTH(DEP)) q_if ();

    vector_instr_queue #(
        .DATA_FROM_SCALAR (DW),
        .DEPTH            (DEP),
        .ALMOST_FULL_LEVEL(AFL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (q_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb_q [$];
    int            m_cnt = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sample on the falling edge, advance the model by what the next rising edge will do.
    task automatic tick();
        logic push_acc;
        logic pop_acc;
        @(negedge clk);
        check_eq("count",       q_if.count,       m_cnt);
        check_eq("valid_fifo",  q_if.valid_fifo,  m_cnt != 0);
        check_eq("push_ready",  q_if.push_ready,  m_cnt != DEP);
        check_eq("almost_full", q_if.almost_full, m_cnt >= AFL);
        if (m_cnt == 0) check_eq("idle_instr", q_if.instruction, '0);
        else            check_eq("head_instr", q_if.instruction, sb_q[0]);
        push_acc = q_if.push_valid && (m_cnt != DEP);
        pop_acc  = q_if.ready && (m_cnt != 0);
        if (!rst || q_if.flush) begin
            sb_q.delete();
            m_cnt = 0;
        end else begin
            if (pop_acc)  void'(sb_q.pop_front());
            if (push_acc) sb_q.push_back(q_if.push_data);
            m_cnt = m_cnt + int'(push_acc) - int'(pop_acc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        q_if.push_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            q_if.push_data = base + DW'(i);
            tick();
        end
        q_if.push_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        q_if.ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        q_if.ready = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        q_if.push_valid = 1'b0;
        q_if.push_data  = '0;
        q_if.ready      = 1'b0;
        q_if.flush      = 1'b0;

        // Reset held for 3 cycles, then idle for 5, then ready on an empty queue.
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        pop_n(3);

        // Fill to full, offer a 9th packet that must be ignored, drain; three rounds for wrap.
        for (int r = 0; r < 3; r++) begin
            push_n(DEP, DW'(1));
            check_eq("full_count", q_if.count, DEP);
            q_if.push_valid = 1'b1;
            q_if.push_data  = DW'(9);
            tick();
            q_if.push_valid = 1'b0;
            pop_n(DEP);
            check_eq("drained_count", q_if.count, 0);
        end

        // Sustained push+pop at occupancy 3.
        push_n(3, DW'('h100));
        q_if.push_valid = 1'b1;
        q_if.ready      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            q_if.push_data = DW'('h0A00 + i);
            tick();
        end
        q_if.push_valid = 1'b0;
        q_if.ready      = 1'b0;
        check_eq("steady_count", q_if.count, 3);

        // Full plus pop: push rejected, then accepted the next cycle.
        push_n(5, DW'('h200));
        q_if.push_valid = 1'b1;
        q_if.push_data  = DW'('hBEEF);
        q_if.ready      = 1'b1;
        tick();
        check_eq("full_pop_count", q_if.count, 7);
        q_if.ready = 1'b0;
        tick();
        check_eq("refill_count", q_if.count, 8);
        q_if.push_valid = 1'b0;

        // Almost-full walk 8 -> 5 -> 8 -> 5.
        pop_n(3);
        check_eq("af_at5", q_if.almost_full, 1'b0);
        push_n(3, DW'('h300));
        pop_n(3);
        check_eq("af_back5", q_if.almost_full, 1'b0);

        // Flush beats a simultaneous push and pop; 0x55 is next out.
        q_if.flush      = 1'b1;
        q_if.push_valid = 1'b1;
        q_if.push_data  = DW'('hDEAD);
        q_if.ready      = 1'b1;
        tick();
        q_if.flush      = 1'b0;
        q_if.push_valid = 1'b0;
        q_if.ready      = 1'b0;
        check_eq("flush_valid", q_if.valid_fifo, 1'b0);
        push_n(1, DW'('h55));
        check_eq("post_flush_head", q_if.instruction, DW'('h55));
        pop_n(2);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            q_if.push_valid = ($urandom_range(0, 3) != 0);
            q_if.push_data  = {$urandom, $urandom, $urandom};
            q_if.ready      = ($urandom_range(0, 2) != 0);
            q_if.flush      = ($urandom_range(0, 40) == 0);
            tick();
        end
        q_if.push_valid = 1'b0;
        q_if.ready      = 1'b0;
        q_if.flush      = 1'b0;

        // Asynchronous reset mid-operation clears the queue before any clock edge.
        push_n(4, DW'('h400));
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_valid", q_if.valid_fifo, 1'b0);
        check_eq("async_rst_count", q_if.count, 0);
        sb_q.delete();
        m_cnt = 0;
        tick();
        rst = 1'b1;
        push_n(2, DW'('h500));
        pop_n(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
